// File: rtl/pkt_integrity_monitor_if.sv
// Snooped read/write memory channels of one packet-processing datapath.
// Handshake: a beat transfers on a rising clk edge where valid && ready; last marks the final beat.
interface pkt_integrity_monitor_if #(
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0] rdata;
   logic              rvalid;
   logic              rready;
   logic              rlast;
   logic [DATA_W-1:0] wdata;
   logic              wvalid;
   logic              wready;
   logic              wlast;

   modport master (
      output rdata, rvalid, rready, rlast,
      output wdata, wvalid, wready, wlast
   );

   modport slave (
      input rdata, rvalid, rready, rlast,
      input wdata, wvalid, wready, wlast
   );
endinterface

// File: rtl/pkt_integrity_monitor.sv
// Packet data-integrity monitor: captures tracked payload bytes on the read burst and checks them,
// shifted by the header, on the write burst. Define PIM_ERR_CNT_EN to build the error counter.
module pkt_integrity_monitor #(
   parameter int DATA_W    = 32,
   parameter int CNT_W     = 4,
   parameter int NUM_TRACK = 4,
   parameter int HDR_BYTES = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [CNT_W-1:0]           byte_cnt,
   input  logic [3:0]                 data_sel,
   input  logic [NUM_TRACK*CNT_W-1:0] track_idx,
   input  logic [NUM_TRACK-1:0]       track_en,
   pkt_integrity_monitor_if.slave     bus,
   output logic                       busy,
   output logic                       check_done,
   output logic [NUM_TRACK-1:0]       mismatch_vec,
   output logic                       order_err,
   output logic [15:0]                err_cnt,
   output logic [2:0]                 state_dbg
);

   localparam int BPB = DATA_W / 8;
   localparam int BW  = CNT_W + 1;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_CAPTURE  = 3'd1;
   localparam logic [2:0] S_WAIT_OUT = 3'd2;
   localparam logic [2:0] S_COMPARE  = 3'd3;
   localparam logic [2:0] S_REPORT   = 3'd4;

   logic [2:0]                 state, state_nx;
   logic [CNT_W-1:0]           cfg_byte_cnt;
   logic [3:0]                 cfg_sel;
   logic [NUM_TRACK*CNT_W-1:0] cfg_idx;
   logic [NUM_TRACK-1:0]       cfg_en;
   logic [BW-1:0]              rbeat, wbeat;
   logic [7:0]                 exp_byte [NUM_TRACK];
   logic [7:0]                 got_byte [NUM_TRACK];
   logic [7:0]                 exp_nx   [NUM_TRACK];
   logic [7:0]                 got_nx   [NUM_TRACK];
   logic [NUM_TRACK-1:0]       seen, seen_nx;
   logic [NUM_TRACK-1:0]       active, mm_nx;
   logic [31:0]                rd_beat [NUM_TRACK];
   logic [31:0]                rd_lane [NUM_TRACK];
   logic [31:0]                wr_beat [NUM_TRACK];
   logic [31:0]                wr_lane [NUM_TRACK];

   logic                       rnext, wnext, in_idle;
   logic                       rd_acc, wr_acc, rd_bad, wr_bad;
   logic [CNT_W-1:0]           cur_byte_cnt;
   logic [3:0]                 cur_sel;
   logic [NUM_TRACK*CNT_W-1:0] cur_idx;
   logic [NUM_TRACK-1:0]       cur_en;

   assign rnext   = bus.rvalid && bus.rready;
   assign wnext   = bus.wvalid && bus.wready;
   assign in_idle = (state == S_IDLE);

   assign rd_acc = rnext && (state == S_IDLE || state == S_CAPTURE);
   assign wr_acc = wnext && (state == S_WAIT_OUT || state == S_COMPARE);
   assign rd_bad = rnext && (state == S_WAIT_OUT || state == S_COMPARE);
   assign wr_bad = wnext && (state == S_IDLE || state == S_CAPTURE);

   // The first read beat is mapped with the live config, which is latched on that same edge.
   assign cur_byte_cnt = in_idle ? byte_cnt  : cfg_byte_cnt;
   assign cur_sel      = in_idle ? data_sel  : cfg_sel;
   assign cur_idx      = in_idle ? track_idx : cfg_idx;
   assign cur_en       = in_idle ? track_en  : cfg_en;

   assign busy       = !in_idle;
   assign check_done = (state == S_REPORT);
   assign state_dbg  = state;

   always_comb begin
      logic [31:0] k;
      logic [31:0] p;
      k      = '0;
      p      = '0;
      active = '0;
      for (int i = 0; i < NUM_TRACK; i++) begin
         k = 32'(cur_idx[i*CNT_W +: CNT_W]);
         p = k + 32'(HDR_BYTES);
         rd_beat[i] = k / BPB;
         rd_lane[i] = k % BPB;
         case (cur_sel)
            4'd0: begin
               rd_beat[i] = k;
               rd_lane[i] = 32'd0;
            end
            4'd1: begin
               rd_beat[i] = k >> 1;
               rd_lane[i] = {31'd0, k[0]};
            end
            default: ;
         endcase
         // Output side is always fully packed, independent of the read packing mode.
         wr_beat[i] = p / BPB;
         wr_lane[i] = p % BPB;
         active[i]  = cur_en[i] && (cur_idx[i*CNT_W +: CNT_W] <= cur_byte_cnt) && (cur_sel <= 4'd2);
      end
   end

   always_comb begin
      logic [DATA_W-1:0] rsh;
      logic [DATA_W-1:0] wsh;
      rsh     = '0;
      wsh     = '0;
      seen_nx = seen;
      mm_nx   = '0;
      for (int i = 0; i < NUM_TRACK; i++) begin
         exp_nx[i] = exp_byte[i];
         got_nx[i] = got_byte[i];
         rsh = bus.rdata >> (rd_lane[i] * 8);
         wsh = bus.wdata >> (wr_lane[i] * 8);
         if (rd_acc && ({{(32-BW){1'b0}}, rbeat} == rd_beat[i])) begin
            exp_nx[i] = rsh[7:0];
         end
         if (wr_acc && ({{(32-BW){1'b0}}, wbeat} == wr_beat[i])) begin
            got_nx[i]  = wsh[7:0];
            seen_nx[i] = 1'b1;
         end
         mm_nx[i] = active[i] && (!seen_nx[i] || (got_nx[i] != exp_byte[i]));
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:     if (rnext) state_nx = bus.rlast ? S_WAIT_OUT : S_CAPTURE;
         S_CAPTURE:  if (rnext && bus.rlast) state_nx = S_WAIT_OUT;
         S_WAIT_OUT: if (wnext) state_nx = bus.wlast ? S_REPORT : S_COMPARE;
         S_COMPARE:  if (wnext && bus.wlast) state_nx = S_REPORT;
         S_REPORT:   state_nx = S_IDLE;
         default:    state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= S_IDLE;
         cfg_byte_cnt <= '0;
         cfg_sel      <= '0;
         cfg_idx      <= '0;
         cfg_en       <= '0;
         rbeat        <= '0;
         wbeat        <= '0;
         seen         <= '0;
         mismatch_vec <= '0;
         order_err    <= 1'b0;
         for (int i = 0; i < NUM_TRACK; i++) begin
            exp_byte[i] <= '0;
            got_byte[i] <= '0;
         end
      end else begin
         state <= state_nx;
         if (in_idle && rnext) begin
            cfg_byte_cnt <= byte_cnt;
            cfg_sel      <= data_sel;
            cfg_idx      <= track_idx;
            cfg_en       <= track_en;
         end
         if (rd_acc) rbeat <= bus.rlast ? '0 : rbeat + 1'b1;
         if (wr_acc) wbeat <= bus.wlast ? '0 : wbeat + 1'b1;
         for (int i = 0; i < NUM_TRACK; i++) begin
            exp_byte[i] <= exp_nx[i];
            got_byte[i] <= got_nx[i];
         end
         seen <= (state == S_REPORT) ? '0 : seen_nx;
         // Result is taken on the edge that enters REPORT, so it already includes the last write beat.
         if (state_nx == S_REPORT) mismatch_vec <= mm_nx;
         if (rd_bad || wr_bad) order_err <= 1'b1;
      end
   end

`ifdef PIM_ERR_CNT_EN
   logic [15:0] err_cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_cnt_q <= '0;
      end else if ((state_nx == S_REPORT) && (|mm_nx) && (err_cnt_q != 16'hFFFF)) begin
         err_cnt_q <= err_cnt_q + 16'd1;
      end
   end

   assign err_cnt = err_cnt_q;
`else
   assign err_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_pkt_integrity_monitor.sv
// Bench for pkt_integrity_monitor: directed vector table, hand-written corner sequences and
// randomized packets checked against a byte-stream reference model.
module tb_pkt_integrity_monitor;

   localparam int DATA_W    = 32;
   localparam int CNT_W     = 4;
   localparam int NUM_TRACK = 4;
   localparam int HDR_BYTES = 2;
   localparam int BPB       = DATA_W / 8;
   localparam int IW        = NUM_TRACK * CNT_W;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [CNT_W-1:0]     byte_cnt;
   logic [3:0]           data_sel;
   logic [IW-1:0]        track_idx;
   logic [NUM_TRACK-1:0] track_en;
   logic                 busy, check_done, order_err;
   logic [NUM_TRACK-1:0] mismatch_vec;
   logic [15:0]          err_cnt;
   logic [2:0]           state_dbg;

   pkt_integrity_monitor_if #(.DATA_W(DATA_W)) bus ();

   pkt_integrity_monitor #(
      .DATA_W(DATA_W), .CNT_W(CNT_W), .NUM_TRACK(NUM_TRACK), .HDR_BYTES(HDR_BYTES)
   ) dut (
      .clk(clk), .reset(reset), .byte_cnt(byte_cnt), .data_sel(data_sel),
      .track_idx(track_idx), .track_en(track_en), .bus(bus),
      .busy(busy), .check_done(check_done), .mismatch_vec(mismatch_vec),
      .order_err(order_err), .err_cnt(err_cnt), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: actual no finish, required finish within time limit");
      $fatal(1, "timeout");
   end

   int n_checks = 0;
   int n_errors = 0;
   logic [NUM_TRACK-1:0] exp_q[$];
   int exp_err_cnt = 0;

   // Current packet as seen by the reference model.
   logic [7:0]           pay  [64];
   logic [7:0]           outb [64];
   logic [DATA_W-1:0]    rbeats [64];
   logic [DATA_W-1:0]    wbeats [64];
   int                   n_rb, n_wb;
   logic [3:0]           p_sel;
   int                   p_bc;
   logic [IW-1:0]        p_idx;
   logic [NUM_TRACK-1:0] p_en;

   typedef struct {
      logic [3:0]           sel;
      int                   bc;
      logic [IW-1:0]        idx;
      logic [NUM_TRACK-1:0] en;
      logic [7:0]           seed;
      int                   corrupt_p;
      int                   trunc;
      logic [NUM_TRACK-1:0] exp_mm;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   function automatic int exp_err_val();
`ifdef PIM_ERR_CNT_EN
      return exp_err_cnt;
`else
      return 0;
`endif
   endfunction

   // Builds payload, read beats in the chosen packing and the header-shifted output stream.
   task automatic build_pkt(input logic [3:0] sel, input int bc, input logic [IW-1:0] idx,
                            input logic [NUM_TRACK-1:0] en, input logic [7:0] seed,
                            input int corrupt_p, input int trunc);
      int total, full;
      p_sel = sel; p_bc = bc; p_idx = idx; p_en = en;
      for (int k = 0; k < 64; k++) begin
         pay[k]    = (k <= bc) ? ((8'(k) * 8'h11) ^ seed) : 8'($urandom);
         rbeats[k] = DATA_W'($urandom);
         outb[k]   = 8'($urandom);
      end
      case (sel)
         4'd0: begin
            n_rb = bc + 1;
            for (int k = 0; k <= bc; k++) rbeats[k][7:0] = pay[k];
         end
         4'd1: begin
            n_rb = (bc + 2) / 2;
            for (int k = 0; k <= bc; k++) rbeats[k/2][8*(k%2) +: 8] = pay[k];
         end
         default: begin
            n_rb = (bc + BPB) / BPB;
            for (int k = 0; k <= bc; k++) rbeats[k/BPB][8*(k%BPB) +: 8] = pay[k];
         end
      endcase
      for (int k = 0; k <= bc; k++) outb[k + HDR_BYTES] = pay[k];
      if (corrupt_p >= 0) outb[corrupt_p] = ~outb[corrupt_p];
      total = bc + 1 + HDR_BYTES;
      full  = (total + BPB - 1) / BPB;
      n_wb  = (trunc > 0 && trunc < full) ? trunc : full;
      for (int j = 0; j < full; j++)
         for (int l = 0; l < BPB; l++) wbeats[j][8*l +: 8] = outb[j*BPB + l];
   endtask

   // Reference: payload byte k must reappear at output stream position k + HDR_BYTES.
   function automatic logic [NUM_TRACK-1:0] model_mm();
      logic [NUM_TRACK-1:0] m;
      int k, p;
      bit act, seen;
      m = '0;
      for (int i = 0; i < NUM_TRACK; i++) begin
         k    = int'(p_idx[i*CNT_W +: CNT_W]);
         act  = p_en[i] && (k <= p_bc) && (p_sel <= 4'd2);
         p    = k + HDR_BYTES;
         seen = (p / BPB) < n_wb;
         m[i] = act && (!seen || outb[p] != pay[k]);
      end
      return m;
   endfunction

   task automatic apply_cfg();
      byte_cnt  = CNT_W'(p_bc);
      data_sel  = p_sel;
      track_idx = p_idx;
      track_en  = p_en;
   endtask

   task automatic drive_read(input int first, input int last_excl);
      int j, stall;
      j = first; stall = 0;
      while (j < last_excl) begin
         @(negedge clk);
         if (j > 0) begin
            byte_cnt  = CNT_W'($urandom);
            data_sel  = 4'($urandom);
            track_idx = IW'($urandom);
            track_en  = NUM_TRACK'($urandom);
         end
         bus.rdata = rbeats[j];
         bus.rlast = (j == n_rb - 1);
         if (stall >= 3) begin
            bus.rvalid = 1'b1; bus.rready = 1'b1;
         end else begin
            bus.rvalid = ($urandom_range(0, 4) != 0);
            bus.rready = ($urandom_range(0, 3) != 0);
         end
         if (bus.rvalid && bus.rready) begin j++; stall = 0; end
         else stall++;
      end
      @(negedge clk);
      bus.rvalid = 1'b0; bus.rready = 1'b0; bus.rlast = 1'b0;
   endtask

   task automatic drive_write(input int first, input int last_excl);
      int j, stall;
      j = first; stall = 0;
      while (j < last_excl) begin
         @(negedge clk);
         bus.wdata = wbeats[j];
         bus.wlast = (j == n_wb - 1);
         if (stall >= 3) begin
            bus.wvalid = 1'b1; bus.wready = 1'b1;
         end else begin
            bus.wvalid = ($urandom_range(0, 4) != 0);
            bus.wready = ($urandom_range(0, 3) != 0);
         end
         if (bus.wvalid && bus.wready) begin
            if (bus.wlast) check("done_early", {31'd0, check_done}, 32'd0);
            j++; stall = 0;
         end else stall++;
      end
      @(negedge clk);
      bus.wvalid = 1'b0; bus.wready = 1'b0; bus.wlast = 1'b0;
   endtask

   task automatic check_report(input string tag);
      logic [NUM_TRACK-1:0] exp_mm;
      check({tag, "_done"}, {31'd0, check_done}, 32'd1);
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      if (exp_q.size() == 0) begin
         n_checks++; n_errors++;
         $display("FAIL %s_sb: actual empty queue, required pending entry", tag);
         exp_mm = '0;
      end else begin
         exp_mm = exp_q.pop_front();
      end
      check({tag, "_mm"}, 32'(mismatch_vec), 32'(exp_mm));
      check({tag, "_errcnt"}, 32'(err_cnt), 32'(exp_err_val()));
      @(negedge clk);
      check({tag, "_pulse"}, {31'd0, check_done}, 32'd0);
      check({tag, "_idle"}, {31'd0, busy}, 32'd0);
      check({tag, "_hold"}, 32'(mismatch_vec), 32'(exp_mm));
   endtask

   task automatic push_exp(input logic [NUM_TRACK-1:0] m);
      exp_q.push_back(m);
      if (m != '0 && exp_err_cnt < 65535) exp_err_cnt++;
   endtask

   task automatic run_packet(input logic [NUM_TRACK-1:0] exp_mm, input string tag);
      push_exp(exp_mm);
      apply_cfg();
      drive_read(0, n_rb);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      drive_write(0, n_wb);
      check_report(tag);
   endtask

   task automatic run_vec(input int v);
      build_pkt(vecs[v].sel, vecs[v].bc, vecs[v].idx, vecs[v].en, vecs[v].seed,
                vecs[v].corrupt_p, vecs[v].trunc);
      run_packet(vecs[v].exp_mm, $sformatf("vec%0d", v));
   endtask

   initial begin
      vecs[0] = '{sel:4'd2, bc:7,  idx:16'h0257, en:4'hF,    seed:8'hF0, corrupt_p:-1, trunc:0, exp_mm:4'b0000};
      vecs[1] = '{sel:4'd2, bc:7,  idx:16'h0257, en:4'hF,    seed:8'hF0, corrupt_p:7,  trunc:0, exp_mm:4'b0010};
      vecs[2] = '{sel:4'd1, bc:3,  idx:16'h0003, en:4'b0001, seed:8'h0F, corrupt_p:-1, trunc:0, exp_mm:4'b0000};
      vecs[3] = '{sel:4'd2, bc:4,  idx:16'h0149, en:4'hF,    seed:8'h5C, corrupt_p:-1, trunc:1, exp_mm:4'b0010};
      vecs[4] = '{sel:4'd0, bc:5,  idx:16'h2305, en:4'hF,    seed:8'h21, corrupt_p:5,  trunc:0, exp_mm:4'b0100};
      vecs[5] = '{sel:4'd3, bc:5,  idx:16'h2305, en:4'hF,    seed:8'h77, corrupt_p:2,  trunc:0, exp_mm:4'b0000};
      vecs[6] = '{sel:4'd2, bc:15, idx:16'h18EF, en:4'b1010, seed:8'h3A, corrupt_p:17, trunc:0, exp_mm:4'b0000};
      vecs[7] = '{sel:4'd1, bc:6,  idx:16'h3216, en:4'hF,    seed:8'hC3, corrupt_p:3,  trunc:0, exp_mm:4'b0010};
      vecs[8] = '{sel:4'd0, bc:0,  idx:16'h0000, en:4'b0001, seed:8'h99, corrupt_p:2,  trunc:0, exp_mm:4'b0001};
      vecs[9] = '{sel:4'd2, bc:6,  idx:16'h0076, en:4'b0011, seed:8'h4E, corrupt_p:8,  trunc:0, exp_mm:4'b0001};

      reset = 1'b0;
      byte_cnt = '0; data_sel = '0; track_idx = '0; track_en = '0;
      bus.rdata = '0; bus.rvalid = 1'b0; bus.rready = 1'b0; bus.rlast = 1'b0;
      bus.wdata = '0; bus.wvalid = 1'b0; bus.wready = 1'b0; bus.wlast = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, check_done}, 32'd0);
      check("rst_mm", 32'(mismatch_vec), 32'd0);
      check("rst_order", {31'd0, order_err}, 32'd0);
      check("rst_errcnt", 32'(err_cnt), 32'd0);
      reset = 1'b1;
      @(negedge clk);

      for (int v = 0; v < 10; v++) run_vec(v);

      for (int n = 0; n < 40; n++) begin
         logic [3:0] sel;
         int bc, total, full, cp, tr;
         sel   = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(3, 15)) : 4'($urandom_range(0, 2));
         bc    = $urandom_range(0, 15);
         total = bc + 1 + HDR_BYTES;
         full  = (total + BPB - 1) / BPB;
         cp    = ($urandom_range(0, 1) == 1) ? $urandom_range(0, total - 1) : -1;
         tr    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, full) : 0;
         build_pkt(sel, bc, IW'($urandom), NUM_TRACK'($urandom), 8'($urandom), cp, tr);
         run_packet(model_mm(), $sformatf("rnd%0d", n));
      end
      check("clean_order", {31'd0, order_err}, 32'd0);

      // Read beat during WAIT_OUT: flagged and ignored (it would corrupt beat-0 slots otherwise).
      build_pkt(4'd2, 7, 16'h0257, 4'hF, 8'hF0, -1, 0);
      push_exp(4'b0000);
      apply_cfg();
      drive_read(0, n_rb);
      @(negedge clk);
      bus.rdata = ~rbeats[0]; bus.rvalid = 1'b1; bus.rready = 1'b1; bus.rlast = 1'b1;
      @(negedge clk);
      bus.rvalid = 1'b0; bus.rready = 1'b0; bus.rlast = 1'b0;
      check("wait_order", {31'd0, order_err}, 32'd1);
      drive_write(0, n_wb);
      check_report("waitrd");

      // Reset in COMPARE aborts the packet and clears everything.
      build_pkt(4'd2, 7, 16'h0257, 4'hF, 8'hF0, 7, 0);
      apply_cfg();
      drive_read(0, n_rb);
      drive_write(0, 1);
      check("cmp_busy", {31'd0, busy}, 32'd1);
      reset = 1'b0;
      #1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, check_done}, 32'd0);
      check("abort_mm", 32'(mismatch_vec), 32'd0);
      check("abort_order", {31'd0, order_err}, 32'd0);
      check("abort_errcnt", 32'(err_cnt), 32'd0);
      exp_err_cnt = 0;
      @(negedge clk);
      check("abort_nodone", {31'd0, check_done}, 32'd0);
      reset = 1'b1;
      @(negedge clk);
      run_vec(0);

      // Write beat during CAPTURE: flagged, ignored, and sticky through later clean packets.
      build_pkt(4'd0, 3, 16'h0123, 4'hF, 8'h6B, -1, 0);
      push_exp(4'b0000);
      apply_cfg();
      drive_read(0, 1);
      @(negedge clk);
      bus.wdata = DATA_W'($urandom); bus.wvalid = 1'b1; bus.wready = 1'b1; bus.wlast = 1'b1;
      @(negedge clk);
      bus.wvalid = 1'b0; bus.wready = 1'b0; bus.wlast = 1'b0;
      check("cap_order", {31'd0, order_err}, 32'd1);
      check("cap_busy", {31'd0, busy}, 32'd1);
      drive_read(1, n_rb);
      drive_write(0, n_wb);
      check_report("capwr");
      run_vec(2);
      run_vec(1);
      check("sticky_order", {31'd0, order_err}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
